// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N:1 stream multiplexer: arbitration mode
// constants, output register states and the channel-index width helper.
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Width of a channel index; a single channel still needs one bit
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_if.sv
// Producer-side and consumer-side stream signals of the multiplexer.
// The slave modport is the multiplexer's view; master is the environment.
interface mux_arb_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
);

  localparam int CH_W = ch_width(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_ch
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_ch
  );

endinterface

// File: rtl/mux_arb_rr_arbiter.sv
// Combinational grant logic. In round-robin mode the search starts at ptr
// and wraps; in fixed mode the lowest requesting index always wins.
// gnt is one-hot and gated by en; gnt_idx reports the winner regardless.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int CH_W = ch_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic found;

  // Two-pass search: first the indices at or above the pointer, then the
  // wrapped part below it. In fixed mode the first pass covers everything.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && ((MODE == MODE_FIXED) || (j >= int'(ptr)))) begin
        found   = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
  end

  // One-hot grant, only when the output register can take a beat
  always_comb begin
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      gnt[j] = en && found && (int'(gnt_idx) == j);
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Registered, flow-controlled N:1 stream multiplexer. One output register
// (EMPTY/FULL) is refilled whenever it is empty or being drained, giving
// one beat per cycle. The winning channel's data is picked with a one-hot
// AND-OR over the flat input bus.
module mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MODE_RR,
  localparam int CH_W = ch_width(N)
) (
  input  logic      clk,
  input  logic      rst,
  mux_arb_if.slave  bus
);

  out_state_t       state_reg, state_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [CH_W-1:0]  out_ch_reg, out_ch_next;
  logic [CH_W-1:0]  ptr_reg, ptr_next;

  logic             load_en;
  logic             arb_en;
  logic             xfer;
  logic [N-1:0]     gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic [WIDTH-1:0] masked [N];
  logic [WIDTH-1:0] sel_data;

  // The register can accept a beat when empty or when its beat leaves now;
  // nothing is offered to producers while reset is held
  always_comb begin
    load_en = (state_reg == ST_EMPTY) || bus.out_ready;
    arb_en  = load_en && !rst;
  end

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Per-channel data gated by its grant bit
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign masked[gi] = {WIDTH{gnt[gi]}} & bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // OR the gated channels together; at most one is non-zero
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      sel_data = sel_data | masked[k];
    end
  end

  assign xfer = |gnt;

  // Next state of the output register and round-robin pointer
  always_comb begin
    state_next    = state_reg;
    out_data_next = out_data_reg;
    out_ch_next   = out_ch_reg;
    ptr_next      = ptr_reg;
    if (load_en) begin
      if (xfer) begin
        state_next    = ST_FULL;
        out_data_next = sel_data;
        out_ch_next   = gnt_idx;
        if (MODE == MODE_RR) begin
          ptr_next = (gnt_idx == CH_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        // Drained with nobody requesting: data and channel keep last values
        state_next = ST_EMPTY;
      end
    end
  end

  // State, data and pointer registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      out_data_reg <= '0;
      out_ch_reg   <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      out_ch_reg   <= out_ch_next;
      ptr_reg      <= ptr_next;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = (state_reg == ST_FULL);
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: three instances (N=4 round-robin, N=4 fixed priority,
// N=2 WIDTH=1 fixed) driven by directed vectors. A queue-free behavioural
// model tracks each instance's output beat; every cycle its outputs and
// in_ready are compared, plus literal expectations at key points.
module tb_mux_arb;
  import mux_pkg::*;

  localparam int NDUT = 3;
  localparam int N_OF    [NDUT] = '{4, 4, 2};
  localparam int MODE_OF [NDUT] = '{MODE_RR, MODE_FIXED, MODE_FIXED};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Stimulus per instance
  logic [3:0] iv   [NDUT];
  logic [7:0] idat [NDUT][4];
  logic       ordy [NDUT];

  mux_arb_if #(.WIDTH(8), .N(4)) if_rr ();
  mux_arb_if #(.WIDTH(8), .N(4)) if_fx ();
  mux_arb_if #(.WIDTH(1), .N(2)) if_lg ();

  assign if_rr.in_data   = {idat[0][3], idat[0][2], idat[0][1], idat[0][0]};
  assign if_rr.in_valid  = iv[0];
  assign if_rr.out_ready = ordy[0];
  assign if_fx.in_data   = {idat[1][3], idat[1][2], idat[1][1], idat[1][0]};
  assign if_fx.in_valid  = iv[1];
  assign if_fx.out_ready = ordy[1];
  assign if_lg.in_data   = {idat[2][1][0], idat[2][0][0]};
  assign if_lg.in_valid  = iv[2][1:0];
  assign if_lg.out_ready = ordy[2];

  mux_arb #(.WIDTH(8), .N(4), .MODE(MODE_RR))    u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  mux_arb #(.WIDTH(8), .N(4), .MODE(MODE_FIXED)) u_fx (.clk(clk), .rst(rst), .bus(if_fx));
  mux_arb #(.WIDTH(1), .N(2), .MODE(MODE_FIXED)) u_lg (.clk(clk), .rst(rst), .bus(if_lg));

  // DUT outputs gathered into uniform arrays
  logic       a_v [NDUT];
  logic [7:0] a_d [NDUT];
  logic [1:0] a_c [NDUT];
  logic [3:0] a_r [NDUT];
  always_comb begin
    a_v[0] = if_rr.out_valid; a_d[0] = if_rr.out_data; a_c[0] = if_rr.out_ch; a_r[0] = if_rr.in_ready;
    a_v[1] = if_fx.out_valid; a_d[1] = if_fx.out_data; a_c[1] = if_fx.out_ch; a_r[1] = if_fx.in_ready;
    a_v[2] = if_lg.out_valid; a_d[2] = {7'b0, if_lg.out_data};
    a_c[2] = {1'b0, if_lg.out_ch}; a_r[2] = {2'b0, if_lg.in_ready};
  end

  // Model state: the beat sitting in each output register and the RR pointer
  int m_v [NDUT];
  int m_d [NDUT];
  int m_c [NDUT];
  int m_p [NDUT];

  // First requesting channel in circular order starting at p; -1 if none
  function automatic int pick(input logic [3:0] m, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (p + k) % n;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int k);
    int g;
    if (rst) return 0;
    if (m_v[k] != 0 && !ordy[k]) return 0;
    g = pick(iv[k], N_OF[k], (MODE_OF[k] == MODE_FIXED) ? 0 : m_p[k]);
    return (g < 0) ? 0 : (1 << g);
  endfunction

  // Behavioural model of every instance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        m_v[k] <= 0; m_d[k] <= 0; m_c[k] <= 0; m_p[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        int g;
        if (m_v[k] == 0 || ordy[k]) begin
          g = pick(iv[k], N_OF[k], (MODE_OF[k] == MODE_FIXED) ? 0 : m_p[k]);
          if (g >= 0) begin
            m_v[k] <= 1;
            m_d[k] <= int'(idat[k][g]) & ((k == 2) ? 1 : 255);
            m_c[k] <= g;
            if (MODE_OF[k] == MODE_RR) m_p[k] <= (g + 1) % N_OF[k];
          end else begin
            m_v[k] <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("dut%0d out_valid", k), 32'(a_v[k]), 32'(m_v[k]));
      chk($sformatf("dut%0d out_data", k),  32'(a_d[k]), 32'(m_d[k]));
      chk($sformatf("dut%0d out_ch", k),    32'(a_c[k]), 32'(m_c[k]));
      chk($sformatf("dut%0d in_ready", k),  32'(a_r[k]), 32'(exp_ready(k)));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      iv[k] = '0; ordy[k] = 1'b1;
      for (int c = 0; c < 4; c++) idat[k][c] = '0;
    end
    step(); step();
    rst = 1'b0;

    // Single request on channel 2
    iv[0] = 4'b0100; idat[0][2] = 8'hA5;
    step();
    chk("single valid", 32'(if_rr.out_valid), 32'd1);
    chk("single data",  32'(if_rr.out_data),  32'hA5);
    chk("single ch",    32'(if_rr.out_ch),    32'd2);
    $display("single: ch=%0d data=%h", if_rr.out_ch, if_rr.out_data);
    iv[0] = 4'b0000;
    step();
    chk("single drain", 32'(if_rr.out_valid), 32'd0);

    // Reset asserted while channel 2 is waiting behind a stalled beat
    iv[0] = 4'b0100; idat[0][2] = 8'h5A; ordy[0] = 1'b0;
    step();
    chk("pre-reset data", 32'(if_rr.out_data), 32'h5A);
    step();
    rst = 1'b1; ordy[0] = 1'b1;
    #1;
    chk("rst valid", 32'(if_rr.out_valid), 32'd0);
    chk("rst data",  32'(if_rr.out_data),  32'h00);
    chk("rst ch",    32'(if_rr.out_ch),    32'd0);
    chk("rst ready", 32'(if_rr.in_ready),  32'd0);
    $display("reset: valid=%0d data=%h ready=%b", if_rr.out_valid, if_rr.out_data, if_rr.in_ready);
    step();
    rst = 1'b0;
    iv[0] = 4'b1111;
    for (int c = 0; c < 4; c++) idat[0][c] = 8'h10 + 8'(c);

    // Round-robin rotation and wrap
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr ch",   32'(if_rr.out_ch),   32'(i % 4));
      chk("rr data", 32'(if_rr.out_data), 32'(8'h10 + i % 4));
      $display("rr beat %0d: ch=%0d data=%h", i, if_rr.out_ch, if_rr.out_data);
    end
    iv[0] = 4'b1001;
    step();
    chk("rr after 3", 32'(if_rr.out_ch), 32'd0);
    step();
    chk("rr next", 32'(if_rr.out_ch), 32'd3);
    iv[0] = 4'b0000;
    step();
    chk("rr drain", 32'(if_rr.out_valid), 32'd0);

    // Backpressure: hold 8'h3C for five stalled cycles
    iv[0] = 4'b0001; idat[0][0] = 8'h3C; ordy[0] = 1'b0;
    step();
    iv[0] = 4'b1000; idat[0][3] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp data",  32'(if_rr.out_data),  32'h3C);
      chk("bp valid", 32'(if_rr.out_valid), 32'd1);
      chk("bp ready", 32'(if_rr.in_ready),  32'd0);
      $display("stall %0d: data=%h ready=%b", i, if_rr.out_data, if_rr.in_ready);
    end
    ordy[0] = 1'b1;
    step();
    chk("bp release data",  32'(if_rr.out_data),  32'h77);
    chk("bp release valid", 32'(if_rr.out_valid), 32'd1);
    iv[0] = 4'b0000;
    step();

    // Fixed priority
    iv[1] = 4'b1110;
    for (int c = 0; c < 4; c++) idat[1][c] = 8'h20 + 8'(c);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fixed ch",   32'(if_fx.out_ch),   32'd1);
      chk("fixed data", 32'(if_fx.out_data), 32'h21);
      $display("fixed beat %0d: ch=%0d data=%h", i, if_fx.out_ch, if_fx.out_data);
    end
    iv[1] = 4'b1100;
    step();
    chk("fixed drop", 32'(if_fx.out_ch), 32'd2);
    iv[1] = 4'b0000;
    step();

    // Two-input legacy mapping: x1 = 0 on channel 0, x2 = 1 on channel 1
    idat[2][0] = 8'h00; idat[2][1] = 8'h01; iv[2] = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("legacy both ch",   32'(if_lg.out_ch),   32'd0);
      chk("legacy both data", 32'(if_lg.out_data), 32'd0);
      $display("legacy both: ch=%0d f=%0d", if_lg.out_ch, if_lg.out_data);
    end
    iv[2] = 4'b0010;
    step();
    chk("legacy x2 ch",   32'(if_lg.out_ch),   32'd1);
    chk("legacy x2 data", 32'(if_lg.out_data), 32'd1);
    $display("legacy x2: ch=%0d f=%0d", if_lg.out_ch, if_lg.out_data);
    iv[2] = 4'b0000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
